// File: rtl/sevenseg_display_arbiter_if.sv
// Bundle between the display requesters and the arbiter that shares the 4-digit display.
// The requester side drives req/req_value and the arbiter drives the grant and display value.
`timescale 1ns/1ps
interface sevenseg_display_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]    req;
   logic [16*N_REQ-1:0] req_value;
   logic [N_REQ-1:0]    gnt;
   logic [15:0]         value;
   logic [2:0]          owner;
   logic                busy;
   logic                switch_p;

   modport master (
      output req, req_value,
      input  gnt, value, owner, busy, switch_p
   );

   modport slave (
      input  req, req_value,
      output gnt, value, owner, busy, switch_p
   );
endinterface

// File: rtl/sevenseg_display_arbiter.sv
// Round-robin owner of the seven-segment display with a guaranteed minimum hold time per owner,
// so that each shown value stays up long enough for a person to read it.
`timescale 1ns/1ps
module sevenseg_display_arbiter #(
   parameter int          N_REQ      = 4,
   parameter int          HOLD_TICKS = 50_000_000,
   parameter logic [15:0] IDLE_VALUE = 16'h0000
) (
   input  logic                     clk,
   input  logic                     rst,
   sevenseg_display_arbiter_if.slave arb_if
);
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = $clog2(HOLD_TICKS + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_TICKS - 1);

   typedef enum logic [1:0] {S_IDLE, S_OWN, S_LINGER} state_t;

   state_t           state_q;
   logic [N_REQ-1:0] gnt_q;
   logic [15:0]      value_q;
   logic [IW-1:0]    owner_q;
   logic [IW-1:0]    rr_q;
   logic [CW-1:0]    cnt_q;
   logic             switch_q;
   logic             busy_q;

   logic [15:0]      val_arr [N_REQ];
   logic [15:0]      owner_val;
   logic [N_REQ-1:0] owner_oh;
   logic [N_REQ-1:0] others;
   logic [IW:0]      pick_all;
   logic [IW:0]      pick_oth;
   logic             expired;
   logic             grant_en_d;
   logic [IW-1:0]    grant_sel_d;

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_val
         assign val_arr[gi] = arb_if.req_value[16*gi +: 16];
      end
   endgenerate

   // Scan rr+1, rr+2, ... with wrap; result is {found, index}.
   function automatic logic [IW:0] pick(input logic [N_REQ-1:0] mask, input logic [IW-1:0] ptr);
      logic          found;
      logic [IW-1:0] sel;
      int            idx;
      found = 1'b0;
      sel   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(ptr) + k) % N_REQ;
         if (!found && mask[IW'(idx)]) begin
            found = 1'b1;
            sel   = IW'(idx);
         end
      end
      return {found, sel};
   endfunction

   assign owner_val = val_arr[owner_q];
   assign owner_oh  = N_REQ'(1) << owner_q;
   assign others    = arb_if.req & ~owner_oh;
   assign pick_all  = pick(arb_if.req, rr_q);
   assign pick_oth  = pick(others, rr_q);
   assign expired   = (cnt_q == CNT_MAX);

   // Hold expiry takes priority over an owner drop, so a drop at expiry never lingers.
   always_comb begin
      grant_en_d  = 1'b0;
      grant_sel_d = pick_all[IW-1:0];
      case (state_q)
         S_IDLE:   grant_en_d = pick_all[IW];
         S_OWN: begin
            if (expired && pick_oth[IW]) begin
               grant_en_d  = 1'b1;
               grant_sel_d = pick_oth[IW-1:0];
            end
         end
         S_LINGER: grant_en_d = expired && pick_all[IW];
         default:  grant_en_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         gnt_q    <= '0;
         value_q  <= IDLE_VALUE;
         owner_q  <= '0;
         rr_q     <= IW'(N_REQ - 1);
         cnt_q    <= '0;
         switch_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         switch_q <= grant_en_d;
         if (grant_en_d) begin
            state_q <= S_OWN;
            gnt_q   <= N_REQ'(1) << grant_sel_d;
            owner_q <= grant_sel_d;
            rr_q    <= grant_sel_d;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            if (state_q == S_OWN) value_q <= owner_val;
         end else begin
            case (state_q)
               S_OWN: begin
                  if (expired && !arb_if.req[owner_q]) begin
                     state_q <= S_IDLE;
                     gnt_q   <= '0;
                     value_q <= IDLE_VALUE;
                     busy_q  <= 1'b0;
                  end else if (!arb_if.req[owner_q]) begin
                     state_q <= S_LINGER;
                     gnt_q   <= '0;
                     cnt_q   <= cnt_q + CW'(1);
                  end else begin
                     value_q <= owner_val;
                     if (!expired) cnt_q <= cnt_q + CW'(1);
                  end
               end
               S_LINGER: begin
                  if (expired) begin
                     state_q <= S_IDLE;
                     value_q <= IDLE_VALUE;
                     busy_q  <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign arb_if.gnt      = gnt_q;
   assign arb_if.value    = value_q;
   assign arb_if.owner    = 3'(owner_q);
   assign arb_if.busy     = busy_q;
   assign arb_if.switch_p = switch_q;
endmodule

// File: tb/tb_sevenseg_display_arbiter.sv
// Bench for the display arbiter: a reference model predicts the outputs after every clock edge
// into a queue, and a monitor on the falling edge pops and compares against the DUT.
`timescale 1ns/1ps
module tb_sevenseg_display_arbiter;
   localparam int          N    = 4;
   localparam int          HOLD = 8;
   localparam logic [15:0] IDLE = 16'hDEAD;

   logic        clk;
   logic        rst;
   logic [15:0] vals [N];

   sevenseg_display_arbiter_if #(.N_REQ(N)) bus ();

   sevenseg_display_arbiter #(
      .N_REQ      (N),
      .HOLD_TICKS (HOLD),
      .IDLE_VALUE (IDLE)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .arb_if (bus.slave)
   );

   assign bus.req_value = {vals[3], vals[2], vals[1], vals[0]};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [3:0]  gnt;
      logic [15:0] value;
      logic [2:0]  owner;
      logic        busy;
      logic        sw;
   } exp_t;

   exp_t exp_q[$];
   int   gnt_log[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
      end
   endtask

   // Reference model: ownership described by who owns the display, whether the owner has
   // walked away, and how many edges have passed since the grant.
   int          m_owner;
   bit          m_dropped;
   int          m_edge;
   int          m_grant_edge;
   int          m_last;
   int          m_shown;
   logic [15:0] m_value;
   bit          m_switch;
   bit          m_expired;
   logic [3:0]  m_others;
   exp_t        m_e;

   function automatic int rr_pick(input logic [3:0] mask, input int after);
      int idx;
      for (int k = 1; k <= N; k++) begin
         idx = (after + k) % N;
         if (mask[idx[1:0]]) return idx;
      end
      return -1;
   endfunction

   task automatic m_grant(input int who);
      m_owner      = who;
      m_last       = who;
      m_shown      = who;
      m_grant_edge = m_edge;
      m_dropped    = 1'b0;
      m_switch     = 1'b1;
   endtask

   task automatic m_release();
      m_owner   = -1;
      m_dropped = 1'b0;
      m_value   = IDLE;
   endtask

   initial begin
      m_owner = -1; m_dropped = 0; m_edge = 0; m_grant_edge = 0;
      m_last = N - 1; m_shown = 0; m_value = IDLE; m_switch = 0;
   end

   always @(posedge clk) begin
      m_edge++;
      m_switch = 1'b0;
      if (rst) begin
         m_owner = -1; m_dropped = 0; m_last = N - 1; m_shown = 0; m_value = IDLE;
      end else begin
         m_expired = (m_edge - m_grant_edge) >= HOLD;
         if (m_owner < 0) begin
            if (bus.req != 4'b0) m_grant(rr_pick(bus.req, m_last));
         end else if (!m_dropped) begin
            m_others = bus.req;
            m_others[m_owner[1:0]] = 1'b0;
            if (m_expired && m_others != 4'b0) begin
               m_value = vals[m_owner[1:0]];
               m_grant(rr_pick(m_others, m_last));
            end else if (m_expired && !bus.req[m_owner[1:0]]) begin
               m_release();
            end else if (!bus.req[m_owner[1:0]]) begin
               m_dropped = 1'b1;
            end else begin
               m_value = vals[m_owner[1:0]];
            end
         end else if (m_expired) begin
            if (bus.req != 4'b0) m_grant(rr_pick(bus.req, m_last));
            else m_release();
         end
      end
      m_e.gnt   = (m_owner >= 0 && !m_dropped) ? 4'(1 << m_owner) : 4'b0;
      m_e.value = m_value;
      m_e.owner = 3'(m_shown);
      m_e.busy  = (m_owner >= 0);
      m_e.sw    = m_switch;
      exp_q.push_back(m_e);
   end

   exp_t mon_e;
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         chk("gnt",      32'(bus.gnt),      32'(mon_e.gnt));
         chk("value",    32'(bus.value),    32'(mon_e.value));
         chk("owner",    32'(bus.owner),    32'(mon_e.owner));
         chk("busy",     32'(bus.busy),     32'(mon_e.busy));
         chk("switch_p", 32'(bus.switch_p), 32'(mon_e.sw));
         if (bus.switch_p === 1'b1) begin
            for (int i = 0; i < N; i++)
               if (bus.gnt[i] === 1'b1) gnt_log.push_back(i);
         end
         $display("cyc t=%0t rst=%0b req=%b gnt=%b value=%h owner=%0d busy=%0b sw=%0b",
                  $time, rst, bus.req, bus.gnt, bus.value, bus.owner, bus.busy, bus.switch_p);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic log_at(input string nm, input int pos, input int expv);
      chk(nm, (gnt_log.size() > pos) ? 32'(gnt_log[pos]) : 32'hFFFF_FFFF, 32'(expv));
   endtask

   int rot_exp [6] = '{0, 1, 3, 0, 1, 3};
   int nb;

   initial begin
      rst = 1'b1;
      bus.req = 4'b0;
      for (int i = 0; i < N; i++) vals[i] = 16'(16'h1000 * (i + 1) + i);

      // Reset with every requester active, then release
      bus.req = 4'b1111;
      tick(2);
      rst = 1'b0;
      tick(3);
      bus.req = 4'b0;
      tick(12);

      // Single requester with live value tracking
      vals[2] = 16'h1234;
      bus.req = 4'b0100;
      tick(3);
      vals[2] = 16'h5678;
      tick(4);
      bus.req = 4'b0;
      tick(12);

      // Rotation from a fresh pointer
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      gnt_log.delete();
      bus.req = 4'b1011;
      tick(50);
      for (int i = 0; i < 6; i++) log_at("rot_order", i, rot_exp[i]);
      bus.req = 4'b0;
      tick(12);

      // Early drop at cnt=3 followed by idle
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      bus.req = 4'b0010;
      tick(4);
      bus.req = 4'b0;
      tick(12);

      // Early drop at cnt=3 with requester 3 waiting through the linger
      gnt_log.delete();
      bus.req = 4'b0010;
      tick(4);
      bus.req = 4'b1000;
      tick(14);
      log_at("drop_then3_a", 0, 1);
      log_at("drop_then3_b", 1, 3);
      bus.req = 4'b0;
      tick(12);

      // Owner drop coinciding with hold expiry while requester 2 waits
      gnt_log.delete();
      bus.req = 4'b0001;
      tick(8);
      bus.req = 4'b0100;
      tick(10);
      log_at("simul_a", 0, 0);
      log_at("simul_b", 1, 2);
      bus.req = 4'b0;
      tick(12);

      // Reset in the middle of owner 3's hold
      gnt_log.delete();
      bus.req = 4'b1000;
      tick(5);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      bus.req = 4'b1001;
      tick(20);
      log_at("midrst_a", 0, 3);
      log_at("midrst_b", 1, 0);
      bus.req = 4'b0;
      tick(12);

      // Random traffic with live value changes and occasional resets
      for (int b = 0; b < 60; b++) begin
         bus.req = 4'($urandom_range(0, 15));
         nb = $urandom_range(1, 12);
         for (int c = 0; c < nb; c++) begin
            if ($urandom_range(0, 3) == 0) vals[$urandom_range(0, 3)] = 16'($urandom);
            rst = ($urandom_range(0, 39) == 0);
            tick(1);
         end
      end
      rst = 1'b0;
      bus.req = 4'b0;
      tick(3);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
